// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver, LSB first, mid-bit sampling off an oversampling clock.
// Emits the byte with a one-clock new_data pulse, or a one-clock frame_error pulse on a bad stop bit.
module uart_rx_8n1 #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       new_data,
    output logic       frame_error,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t          state, next;
    logic            rx_m, rx_s;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            half_done, bit_done;
    logic            sample, stop_ok, stop_bad, bad_state;

    assign half_done = clk_cnt == HALF;
    assign bit_done  = clk_cnt == LAST;

    // Synchronizer flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data        <= '0;
            new_data    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= next;
            clk_cnt     <= (next != state || sample || state == IDLE || state == WAIT_IDLE) ? '0 : clk_cnt + 1'b1;
            bit_idx     <= (state == START) ? 3'd0 : sample ? bit_idx + 3'd1 : bit_idx;
            if (sample)
                shift[bit_idx] <= rx_s;
            data        <= bad_state ? 8'h00 : stop_ok ? shift : data;
            new_data    <= stop_ok;
            frame_error <= stop_bad;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:      next = rx_s ? IDLE : START;
            START:     next = half_done ? (rx_s ? IDLE : DATA) : START;
            DATA:      next = (bit_done && bit_idx == 3'd7) ? STOP : DATA;
            STOP:      next = bit_done ? (rx_s ? IDLE : WAIT_IDLE) : STOP;
            WAIT_IDLE: next = rx_s ? IDLE : WAIT_IDLE;
            default:   next = IDLE;
        endcase
    end

    always_comb begin
        bad_state = !(state inside {IDLE, START, DATA, STOP, WAIT_IDLE});
        busy      = !bad_state && state != IDLE;
        sample    = state == DATA && bit_done;
        stop_ok   = state == STOP && bit_done && rx_s;
        stop_bad  = state == STOP && bit_done && !rx_s;
    end
endmodule
